pattern_scan_ctrl: RTL and testbench

Frame-level controller for the serial sequence-detection path. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first as one bit per cycle. An embedded Mealy-style pattern matcher, with programmable pattern, length and overlap mode, checks the bit stream. The block then returns a per-frame match count and first-match position to the requester over a second valid/ready handshake.

---
 rtl/pattern_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: accepts a parallel word, shifts it out MSB-first and runs a
// programmable Mealy pattern matcher over the bit stream, returning per-frame results.
module pattern_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              match_pulse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  first_pos,
    output logic              match_found
);
    localparam int BS_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [PAT_W-1:0]  pat_q;
    logic [BS_W-1:0]   len_q;
    logic              ovl_q;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [BS_W-1:0]   seen_q, seen_d;
    logic [BS_W:0]     seen_p1;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  first_q;
    logic              found_q;
    logic              in_ready_q;
    logic              ser_valid_q;
    logic              out_valid_q;
    logic [BS_W-1:0]   len_c;
    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  mask;
    logic              hit;

    // Pattern length is clamped once at accept so the matcher never sees an illegal length.
    always_comb begin
        len_c = BS_W'(cfg_len);
        if (cfg_len < 4'd2) begin
            len_c = BS_W'(2);
        end else if (32'(cfg_len) > PAT_W) begin
            len_c = BS_W'(PAT_W);
        end
    end

    always_comb begin
        ser_bit = ser_valid_q & word_q[DATA_W-1];
        window  = {hist_q, ser_bit};
        mask    = (PAT_W'(1) << len_q) - PAT_W'(1);
        seen_p1 = {1'b0, seen_q} + (BS_W + 1)'(1);
        hit     = ser_valid_q && (seen_p1 >= {1'b0, len_q}) &&
                  (((window ^ pat_q) & mask) == '0);
        hist_d  = window[PAT_W-2:0];
        seen_d  = (seen_q == BS_W'(PAT_W)) ? seen_q : seen_q + BS_W'(1);
        // Non-overlapping mode restarts the matcher right after the completing bit.
        if (hit && !ovl_q) begin
            hist_d = '0;
            seen_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            pat_q       <= '0;
            len_q       <= BS_W'(2);
            ovl_q       <= 1'b0;
            hist_q      <= '0;
            seen_q      <= '0;
            k_q         <= '0;
            count_q     <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        word_q      <= in_data;
                        pat_q       <= cfg_pat;
                        len_q       <= len_c;
                        ovl_q       <= cfg_overlap;
                        hist_q      <= '0;
                        seen_q      <= '0;
                        k_q         <= '0;
                        count_q     <= '0;
                        first_q     <= '0;
                        found_q     <= 1'b0;
                        in_ready_q  <= 1'b0;
                        ser_valid_q <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    word_q <= {word_q[DATA_W-2:0], 1'b0};
                    hist_q <= hist_d;
                    seen_q <= seen_d;
                    k_q    <= k_q + CNT_W'(1);
                    if (hit) begin
                        count_q <= count_q + CNT_W'(1);
                        if (!found_q) begin
                            first_q <= k_q;
                            found_q <= 1'b1;
                        end
                    end
                    if (k_q == CNT_W'(DATA_W - 1)) begin
                        ser_valid_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_valid   = ser_valid_q;
    assign match_pulse = hit;
    assign out_valid   = out_valid_q;
    assign match_count = count_q;
    assign first_pos   = first_q;
    assign match_found = found_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized self-checking bench for pattern_scan_ctrl against a bit-list reference model.
module tb_pattern_scan_ctrl;
    localparam int DATA_W = 16;
    localparam int PAT_W  = 8;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [PAT_W-1:0]  cfg_pat = '0;
    logic [3:0]        cfg_len = 4'd3;
    logic              cfg_overlap = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              ser_bit;
    logic              ser_valid;
    logic              match_pulse;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  match_count;
    logic [CNT_W-1:0]  first_pos;
    logic              match_found;

    int checks   = 0;
    int failures = 0;

    pattern_scan_ctrl #(
        .DATA_W(DATA_W),
        .PAT_W (PAT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .match_pulse(match_pulse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .match_count(match_count),
        .first_pos  (first_pos),
        .match_found(match_found)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: list of bits since the last matcher restart, compared against the pattern.
    task automatic model(input logic [DATA_W-1:0] w, input logic [PAT_W-1:0] pat,
                         input logic [3:0] len_raw, input logic ovl,
                         output logic [DATA_W-1:0] pulses, output int cnt, output int first);
        int len;
        int s;
        bit ok;
        if (len_raw < 2) len = 2;
        else if (len_raw > PAT_W) len = PAT_W;
        else len = int'(len_raw);
        pulses = '0;
        cnt    = 0;
        first  = -1;
        s      = 0;
        for (int k = 0; k < DATA_W; k++) begin
            if (k - s + 1 >= len) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++)
                    if (w[DATA_W-1-(k-j)] !== pat[j]) ok = 1'b0;
                if (ok) begin
                    pulses[k] = 1'b1;
                    cnt++;
                    if (first < 0) first = k;
                    if (!ovl) s = k + 1;
                end
            end
        end
        if (first < 0) first = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_ser_bit"}, ser_bit, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_count"}, match_count, 0);
        check({tag, "_first"}, first_pos, 0);
        check({tag, "_found"}, match_found, 0);
        check({tag, "_pulse"}, match_pulse, 0);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] w, input logic [PAT_W-1:0] pat,
                             input logic [3:0] len, input logic ovl, input int hold,
                             input int rst_k, input bit churn);
        logic [DATA_W-1:0] pulses;
        int cnt;
        int first;
        int n;
        model(w, pat, len, ovl, pulses, cnt, first);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", in_ready, 1);
        if (in_ready !== 1'b1) return;
        in_data     = w;
        cfg_pat     = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            if (churn) begin
                cfg_pat     = PAT_W'($urandom);
                cfg_len     = 4'($urandom);
                cfg_overlap = 1'($urandom);
                in_valid    = 1'($urandom);
                in_data     = DATA_W'($urandom);
            end
            check("ser_valid", ser_valid, 1);
            check("ser_bit", ser_bit, w[DATA_W-1-k]);
            check("match_pulse", match_pulse, pulses[k]);
            check("in_ready_shift", in_ready, 0);
            check("out_valid_shift", out_valid, 0);
            if (k == rst_k) begin
                reset    = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                check_idle_outputs("midreset");
                check("midreset_in_ready", in_ready, 0);
                reset = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    check("post_reset_out_valid", out_valid, 0);
                    check("post_reset_ser_valid", ser_valid, 0);
                end
                check("post_reset_in_ready", in_ready, 1);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("out_valid_rise", out_valid, 1);
        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", out_valid, 1);
            check("done_in_ready", in_ready, 0);
            check("done_ser_valid", ser_valid, 0);
            check("done_pulse", match_pulse, 0);
            check("match_count", match_count, cnt);
            check("first_pos", first_pos, first);
            check("match_found", match_found, (cnt > 0) ? 1 : 0);
            if (h < hold) begin
                in_valid = 1'($urandom);
                in_data  = DATA_W'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk); #1;
            check_idle_outputs("reset");
            check("reset_in_ready", in_ready, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_release_in_ready", in_ready, 1);

        run_frame(16'hAAAA, 8'b0000_0101, 4'd3, 1'b1, 0, -1, 1'b0);
        run_frame(16'hAAAA, 8'b0000_0101, 4'd3, 1'b0, 0, -1, 1'b0);
        run_frame(16'h0000, 8'b0000_0101, 4'd3, 1'b1, 0, -1, 1'b0);
        run_frame(16'hAAAA, 8'b0000_0101, 4'd3, 1'b1, 5, -1, 1'b1);
        run_frame(16'h5555, 8'b0000_0001, 4'd0, 1'b1, 0, -1, 1'b0);
        run_frame(16'h5555, 8'b0000_0001, 4'd0, 1'b1, 0, 8, 1'b0);
        run_frame(16'h5555, 8'b0000_0001, 4'd0, 1'b1, 0, -1, 1'b0);
        run_frame(16'hFFFF, 8'hFF, 4'd15, 1'b0, 1, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_frame(DATA_W'($urandom), PAT_W'($urandom), 4'($urandom_range(0, 15) < 10 ?
                      $urandom_range(0, 4) : $urandom_range(5, 15)),
                      1'($urandom), int'($urandom_range(0, 4)), -1, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
